adder10: RTL and testbench
==========================

Name: adder10

Overview:
- Single-digit BCD (decimal) adder with carry-in and carry-out.
- Computes res = (a + b + cin) mod 10 and cout = (a + b + cin) >= 10.
- Outputs are registered, with one-cycle latency.
- Used as the building block for multi-digit decimal adders by rippling cout into the next digit's cin.

Parameters:
- None. All widths are fixed: 4-bit BCD digit, 1-bit carry.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  4  BCD addend digit; legal range 0–9.
- b  input  4  BCD addend digit; legal range 0–9.
- cin  input  1  decimal carry-in.
- in_valid  input  1  qualifies a, b and cin this cycle.
- res  output  4  BCD sum digit, registered.
- cout  output  1  decimal carry-out, registered.
- out_valid  output  1  res, cout and err hold the result of an accepted input.
- err  output  1  at least one of a, b was a non-BCD code (10–15) in the accepted input.

Behaviour:
- Reset: on a rising clk edge with rst=1, res=0, cout=0, out_valid=0 and err=0. rst has priority over in_valid.
- Latency:
  - If in_valid=1 at edge N, the result appears at edge N+1 and out_valid=1 for exactly that cycle.
  - If in_valid=0 at edge N, out_valid=0 after that edge, and res, cout and err hold their previous values.
- Arithmetic:
  - sum5 = a + b + cin, computed as a 5-bit zero-extended sum with range 0–31.
  - If sum5 <= 9: res = sum5[3:0], cout = 0.
  - If sum5 >= 10: res = (sum5 + 6)[3:0], cout = 1. This is the standard +6 correction; for legal inputs it equals sum5 − 10.
- Legal-input range: sum5 is 0–19, res is always 0–9, and cout reflects a decimal carry.
- Illegal digits:
  - err = (a > 9) | (b > 9), registered alongside res.
  - The +6 correction rule is still applied unchanged. Example: a=15, b=15, cin=1 gives sum5=31, so res=5, cout=1, err=1.
- Boundary cases:
  - 9+9+1=19 → res=9, cout=1.
  - 9+0+1=10 → res=0, cout=1.
  - 0+0+0 → res=0, cout=0.
- Back-to-back operation: in_valid may be high every cycle, giving one result per cycle with no stall or backpressure.
- Reset mid-stream: an input accepted at the same edge as rst=1 is discarded.
- No internal state other than the output registers.

Decomposition:
- Package adder10_pkg:
  - typedef bcd_t (logic [3:0]).
  - Constants BCD_MAX=9, BCD_RADIX=10, BCD_CORR=6.
- Sub-module bcd_digit_add, purely combinational:
  - Inputs a, b, cin.
  - Outputs res, cout, err.
  - Contains the sum and correction logic.
- adder10 instantiates bcd_digit_add and adds the valid/output registers and reset.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=5, b=5 → res=0, cout=0, out_valid=0, err=0 throughout.
- No carry: a=3, b=4, cin=0, in_valid=1 → next cycle res=7, cout=0, out_valid=1, err=0; then in_valid=0 → out_valid=0, res holds 7.
- Carry boundaries:
  - a=9, b=0, cin=1 → res=0, cout=1.
  - a=9, b=9, cin=1 → res=9, cout=1.
  - a=4, b=5, cin=0 → res=9, cout=0.
- Exhaustive legal sweep: all a, b in 0–9 and cin in {0,1}, with in_valid held high back-to-back → each result one cycle later equals (a+b+cin) mod 10 with cout = (a+b+cin) >= 10.
- Illegal digits:
  - a=12, b=3, cin=0 → sum5=15, res=5, cout=1, err=1.
  - a=15, b=15, cin=1 → res=5, cout=1, err=1.
- Reset mid-stream: drive a=8, b=7, cin=1 with in_valid=1 and rst=1 on the same edge → out_valid=0 and res=0 next cycle; the following valid input (2+2+0) → res=4.

Source files
------------

// File: rtl/adder10_pkg.sv
// Shared types and constants for the registered BCD digit adder.
// Digit width, radix and the +6 decimal correction live here.
package adder10_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       BCD_MAX   = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;
  localparam bcd_t       BCD_CORR  = 4'd6;

  typedef struct packed {
    bcd_t res;
    logic cout;
    logic err;
  } digit_res_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit decimal add with +6 correction.
// Non-BCD digits are flagged but go through the same correction.
module bcd_digit_add
  import adder10_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] res,
  output logic       cout,
  output logic       err
);

  logic [4:0] sum5;
  logic       carry;

  always_comb begin
    sum5  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    carry = (sum5 >= BCD_RADIX);
    // mod-16 wrap of the low nibble matches (sum5 + 6)[3:0]
    res   = carry ? (sum5[3:0] + BCD_CORR) : sum5[3:0];
    cout  = carry;
    err   = (a > BCD_MAX) | (b > BCD_MAX);
  end

endmodule

// File: rtl/adder10.sv
// Registered BCD digit adder: one result per accepted input,
// one cycle later; outputs hold when no input is accepted.
module adder10
  import adder10_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       in_valid,
  output logic [3:0] res,
  output logic       cout,
  output logic       out_valid,
  output logic       err
);

  digit_res_t sum_c;
  digit_res_t out_d, out_q;
  logic       out_valid_d, out_valid_q;

  bcd_digit_add u_add (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .res  (sum_c.res),
    .cout (sum_c.cout),
    .err  (sum_c.err)
  );

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = sum_c;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign res       = out_q.res;
  assign cout      = out_q.cout;
  assign err       = out_q.err;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder10.sv
// Directed bench for adder10: reset, carries, legal sweep,
// illegal digits and reset landing on an accepted input.
module tb_adder10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       cin, in_valid;
  logic [3:0] res;
  logic       cout, out_valid, err;

  int total = 0;
  int bad   = 0;

  adder10 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .res       (res),
    .cout      (cout),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  // {out_valid, err, cout, res}
  logic [6:0] obs;
  assign obs = {out_valid, err, cout, res};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    a = 4'd5; b = 4'd5; cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs !== 7'b0_0_0_0000) begin
        bad++;
        $display("FAIL reset[%0d] got v=%b e=%b c=%b r=%0d want 0 0 0 0",
                 i, out_valid, err, cout, res);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_no_carry();
    a = 4'd3; b = 4'd4; cin = 1'b0; in_valid = 1'b1;
    tick();
    total++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'd7}) begin
      bad++;
      $display("FAIL no_carry got v=%b e=%b c=%b r=%0d want 1 0 0 7",
               out_valid, err, cout, res);
    end
    in_valid = 1'b0; a = 4'd1; b = 4'd1;
    tick();
    total++;
    if (obs !== {1'b0, 1'b0, 1'b0, 4'd7}) begin
      bad++;
      $display("FAIL hold got v=%b e=%b c=%b r=%0d want 0 0 0 7",
               out_valid, err, cout, res);
    end
  endtask

  task automatic test_carry_bounds();
    logic [3:0] va [3] = '{4'd9, 4'd9, 4'd4};
    logic [3:0] vb [3] = '{4'd0, 4'd9, 4'd5};
    logic       vc [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] er [3] = '{4'd0, 4'd9, 4'd9};
    logic       ec [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
      tick();
      total++;
      if (obs !== {1'b1, 1'b0, ec[i], er[i]}) begin
        bad++;
        $display("FAIL bound[%0d] got v=%b e=%b c=%b r=%0d want 1 0 %b %0d",
                 i, out_valid, err, cout, res, ec[i], er[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int s;
    logic [3:0] er;
    logic       ec;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        for (int k = 0; k < 2; k++) begin
          a = i[3:0]; b = j[3:0]; cin = k[0]; in_valid = 1'b1;
          s  = i + j + k;
          er = 4'(s % 10);
          ec = (s >= 10);
          tick();
          total++;
          if (obs !== {1'b1, 1'b0, ec, er}) begin
            bad++;
            $display("FAIL sweep %0d+%0d+%0d got v=%b e=%b c=%b r=%0d want 1 0 %b %0d",
                     i, j, k, out_valid, err, cout, res, ec, er);
          end
        end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sweep_end got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    a = 4'd12; b = 4'd3; cin = 1'b0; in_valid = 1'b1;
    tick();
    total++;
    if (obs !== {1'b1, 1'b1, 1'b1, 4'd5}) begin
      bad++;
      $display("FAIL illegal_12_3 got v=%b e=%b c=%b r=%0d want 1 1 1 5",
               out_valid, err, cout, res);
    end
    a = 4'd15; b = 4'd15; cin = 1'b1;
    tick();
    total++;
    if (obs !== {1'b1, 1'b1, 1'b1, 4'd5}) begin
      bad++;
      $display("FAIL illegal_15_15 got v=%b e=%b c=%b r=%0d want 1 1 1 5",
               out_valid, err, cout, res);
    end
    in_valid = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
    tick();
    total++;
    if (obs !== {1'b0, 1'b1, 1'b1, 4'd5}) begin
      bad++;
      $display("FAIL illegal_hold got v=%b e=%b c=%b r=%0d want 0 1 1 5",
               out_valid, err, cout, res);
    end
  endtask

  task automatic test_mid_reset();
    a = 4'd6; b = 4'd7; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 4'd8; b = 4'd7; cin = 1'b1; rst = 1'b1;
    tick();
    total++;
    if (obs !== 7'b0_0_0_0000) begin
      bad++;
      $display("FAIL mid_reset got v=%b e=%b c=%b r=%0d want 0 0 0 0",
               out_valid, err, cout, res);
    end
    rst = 1'b0; a = 4'd2; b = 4'd2; cin = 1'b0;
    tick();
    total++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'd4}) begin
      bad++;
      $display("FAIL after_reset got v=%b e=%b c=%b r=%0d want 1 0 0 4",
               out_valid, err, cout, res);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_no_carry();
    test_carry_bounds();
    test_back_to_back();
    test_illegal();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
